// File: rtl/ca_engine.sv
// ca_engine: 1-D elementary (radius-1, 2-state) cellular automaton engine.
//
// Evolves a WIDTH-cell row under an 8-bit Wolfram rule. The boundary is
// either a periodic ring (wrap=1) or a null boundary whose edge neighbours
// read boundary_val (wrap=0). Supports single-step and multi-generation runs
// with generation counting and a one-cycle done pulse.
//
// Optional feature macro: CA_ENGINE_FIXPOINT_EN
//   When defined, a run ends early as soon as a computed generation equals
//   the current row. That final update is still applied and counted, and the
//   sticky fixpoint flag is set. When undefined, no comparator is built and
//   fixpoint is tied low.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   rule          Wolfram rule, sampled at every generation update
//   wrap          1: periodic ring, 0: null boundary
//   boundary_val  edge neighbour value when wrap=0
//   state         seed row, loaded on load
//   load          load seed and abort any run (highest priority)
//   step          compute one generation (IDLE only)
//   start         run gen_limit generations (IDLE only)
//   stop          abort a run without a done pulse
//   gen_limit     generations per run, latched at start
//   out           current row
//   gen_count     generations since last load (wraps)
//   out_valid     one-cycle pulse: out holds a newly computed generation
//   busy          high while running
//   done          one-cycle pulse: run finished
//   fixpoint      sticky: last run ended on a fixed point
//
// FSM states:
//   state | meaning
//   IDLE  | waiting; accepts load / start / step
//   RUN   | one generation per clock until remaining hits zero
//   DONE  | single cycle presenting the done pulse, then IDLE

module ca_engine #(
  parameter int WIDTH = 32,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic             boundary_val,
  input  logic [WIDTH-1:0] state,
  input  logic             load,
  input  logic             step,
  input  logic             start,
  input  logic             stop,
  input  logic [GEN_W-1:0] gen_limit,
  output logic [WIDTH-1:0] out,
  output logic [GEN_W-1:0] gen_count,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             fixpoint
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic [GEN_W-1:0] remaining;
  logic [WIDTH+1:0] ext;
  logic [WIDTH-1:0] next_row;
  logic             do_update;
  logic             do_start;
  logic             fix_hit;

  // Row padded with one neighbour on each side: ext[0] is the left
  // neighbour of cell 0, ext[WIDTH+1] the right neighbour of cell WIDTH-1.
  assign ext = {(wrap ? out[0] : boundary_val), out,
                (wrap ? out[WIDTH-1] : boundary_val)};

  always_comb begin
    next_row = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_row[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
    end
  end

`ifdef CA_ENGINE_FIXPOINT_EN
  assign fix_hit = (next_row == out);
`else
  assign fix_hit = 1'b0;
`endif

  always_comb begin
    fsm_d     = fsm_q;
    do_update = 1'b0;
    do_start  = 1'b0;
    if (load) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE: begin
          // stop outranks start/step even though there is nothing to abort
          if (stop) begin
            fsm_d = IDLE;
          end else if (start) begin
            do_start = 1'b1;
            fsm_d    = (gen_limit == '0) ? DONE : RUN;
          end else if (step) begin
            do_update = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            fsm_d = IDLE;
          end else begin
            do_update = 1'b1;
            if (remaining == GEN_W'(1) || fix_hit) fsm_d = DONE;
          end
        end
        DONE:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      out       <= '0;
      gen_count <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      out_valid <= do_update;
      busy      <= (fsm_d == RUN);
      done      <= (fsm_d == DONE);
      if (load) begin
        out       <= state;
        gen_count <= '0;
      end else if (do_update) begin
        out       <= next_row;
        gen_count <= gen_count + GEN_W'(1);
      end
      if (do_start) begin
        remaining <= gen_limit;
      end else if (do_update && fsm_q == RUN) begin
        remaining <= remaining - GEN_W'(1);
      end
    end
  end

`ifdef CA_ENGINE_FIXPOINT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixpoint <= 1'b0;
    end else if (load || do_start) begin
      fixpoint <= 1'b0;
    end else if (fsm_q == RUN && do_update && fix_hit) begin
      fixpoint <= 1'b1;
    end
  end
`else
  assign fixpoint = 1'b0;
`endif

endmodule

// File: tb/tb_ca_engine.sv
// Directed bench for ca_engine (WIDTH=8). The stimulus thread carries a
// behavioural model of the row and flags; a compare process checks every
// output on every falling edge. Literal expectations pin the model.
module tb_ca_engine;
  localparam int W = 8;
  localparam int G = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rule;
  logic         wrap;
  logic         boundary_val;
  logic [W-1:0] seed;
  logic         load, step, start, stop;
  logic [G-1:0] gen_limit;
  logic [W-1:0] out;
  logic [G-1:0] gen_count;
  logic         out_valid, busy, done, fixpoint;

  ca_engine #(.WIDTH(W), .GEN_W(G)) dut (
    .clk(clk), .rst(rst), .rule(rule), .wrap(wrap), .boundary_val(boundary_val),
    .state(seed), .load(load), .step(step), .start(start), .stop(stop),
    .gen_limit(gen_limit), .out(out), .gen_count(gen_count),
    .out_valid(out_valid), .busy(busy), .done(done), .fixpoint(fixpoint)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] m_out;
  logic [G-1:0] m_gen;
  logic         e_valid, e_busy, e_done, e_fix;
  bit           chk_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out",       32'(out),       32'(m_out));
      check("gen_count", 32'(gen_count), 32'(m_gen));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("busy",      32'(busy),      32'(e_busy));
      check("done",      32'(done),      32'(e_done));
      check("fixpoint",  32'(fixpoint),  32'(e_fix));
    end
  end

  // Spec-level rule application: neighbourhood value n = 4L+2C+R selects rule bit n.
  function automatic logic [W-1:0] ca_next(input logic [W-1:0] row, input logic [7:0] r,
                                           input logic wr, input logic bv);
    logic [W-1:0] res;
    int l, c, rr, n;
    res = '0;
    for (int i = 0; i < W; i++) begin
      if (i == 0) l = wr ? int'(row[W-1]) : int'(bv);
      else        l = int'(row[i-1]);
      if (i == W-1) rr = wr ? int'(row[0]) : int'(bv);
      else          rr = int'(row[i+1]);
      c = int'(row[i]);
      n = l * 4 + c * 2 + rr;
      res[i] = ((int'(r) >> n) % 2) == 1;
    end
    return res;
  endfunction

  // Advance one edge; control pulses last one cycle, output pulses default low.
  task automatic tick();
    @(posedge clk);
    #1;
    load = 1'b0; step = 1'b0; start = 1'b0; stop = 1'b0;
    e_valid = 1'b0;
    e_done  = 1'b0;
  endtask

  task automatic upd_tick(output bit fixed);
    logic [W-1:0] nxt;
    nxt = ca_next(m_out, rule, wrap, boundary_val);
`ifdef CA_ENGINE_FIXPOINT_EN
    fixed = (nxt == m_out);
`else
    fixed = 1'b0;
`endif
    tick();
    m_out   = nxt;
    m_gen   = m_gen + 16'd1;
    e_valid = 1'b1;
  endtask

  task automatic do_load(input logic [W-1:0] s);
    seed = s; load = 1'b1;
    tick();
    m_out = s; m_gen = '0; e_fix = 1'b0; e_busy = 1'b0;
  endtask

  task automatic do_step();
    bit f;
    step = 1'b1;
    upd_tick(f);
  endtask

  // Run n generations; optionally abort after stop_after updates with stop or load.
  task automatic do_run(input int n, input int stop_after, input bit use_load,
                        input logic [W-1:0] s, input bit noise);
    bit f;
    start = 1'b1; gen_limit = G'(n);
    tick();
    e_fix = 1'b0;
    if (n == 0) begin
      e_done = 1'b1;
    end else begin
      e_busy = 1'b1;
      for (int k = 1; k <= n; k++) begin
        if (noise) begin step = 1'b1; start = 1'b1; end
        upd_tick(f);
        if (k == n || f) begin
          e_busy = 1'b0; e_done = 1'b1;
          if (f) e_fix = 1'b1;
          break;
        end
        if (k == stop_after) begin
          if (use_load) begin
            seed = s; load = 1'b1;
          end else begin
            stop = 1'b1;
          end
          tick();
          e_busy = 1'b0;
          if (use_load) begin m_out = s; m_gen = '0; end
          break;
        end
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; rule = 8'd90; wrap = 1'b1; boundary_val = 1'b0; seed = '0;
    load = 1'b0; step = 1'b0; start = 1'b0; stop = 1'b0; gen_limit = '0;
    m_out = '0; m_gen = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_fix = 1'b0;
    chk_en = 1'b0;
    #12;
    check("rst_out", 32'(out), 32'h0);
    check("rst_gen", 32'(gen_count), 32'h0);
    check("rst_flags", 32'({out_valid, busy, done, fixpoint}), 32'h0);
    chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // rule 90 single steps
    do_load(8'b0001_0000);
    do_step();
    check("r90_step_out", 32'(out), 32'h28);
    check("r90_step_gen", 32'(gen_count), 32'd1);
    check("r90_step_valid", 32'(out_valid), 32'd1);
    tick();
    check("r90_valid_pulse", 32'(out_valid), 32'd0);

    do_load(8'b0000_0001); do_step();
    check("wrap1", 32'(out), 32'h82);
    wrap = 1'b0; boundary_val = 1'b0;
    do_load(8'b0000_0001); do_step();
    check("null_bv0", 32'(out), 32'h02);
    boundary_val = 1'b1;
    do_load(8'b0000_0001); do_step();
    check("null_bv1", 32'(out), 32'h83);
    tick();

    // rule 30 run of 3, step/start noise ignored while running
    rule = 8'd30; wrap = 1'b1; boundary_val = 1'b0;
    do_load(8'h10);
    do_run(3, 0, 1'b0, 8'h00, 1'b1);
    check("r30_run_out", 32'(out), 32'hF6);
    check("r30_run_gen", 32'(gen_count), 32'd3);

    // stop after 4th update
    do_load(8'h10);
    do_run(10, 4, 1'b0, 8'h00, 1'b0);
    check("stop_gen", 32'(gen_count), 32'd4);
    repeat (3) tick();

    // load aborts run after 4th update
    do_load(8'h10);
    do_run(10, 4, 1'b1, 8'h5A, 1'b0);
    check("abort_load_out", 32'(out), 32'h5A);
    check("abort_load_gen", 32'(gen_count), 32'd0);

    // gen_limit = 0: straight to done, row untouched
    do_run(0, 0, 1'b0, 8'h00, 1'b0);
    check("lim0_out", 32'(out), 32'h5A);

    // stop in IDLE outranks start
    stop = 1'b1; start = 1'b1; gen_limit = 16'd5;
    tick();
    tick();

    // identity rule: fixed point on the first update
    rule = 8'd204;
    do_load(8'hA5);
    do_run(10, 0, 1'b0, 8'h00, 1'b0);
`ifdef CA_ENGINE_FIXPOINT_EN
    check("fix_gen", 32'(gen_count), 32'd1);
    check("fix_flag", 32'(fixpoint), 32'd1);
`else
    check("nofix_gen", 32'(gen_count), 32'd10);
    check("nofix_flag", 32'(fixpoint), 32'd0);
`endif
    do_load(8'hA5);
    check("fix_clear", 32'(fixpoint), 32'd0);

    // asynchronous reset mid-run
    rule = 8'd30;
    do_load(8'h10);
    start = 1'b1; gen_limit = 16'd10;
    tick();
    e_busy = 1'b1;
    begin
      bit f;
      upd_tick(f);
      upd_tick(f);
    end
    #2 rst = 1'b1;
    m_out = '0; m_gen = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_fix = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_gen", 32'(gen_count), 32'h0);
    check("arst_flags", 32'({out_valid, busy, done, fixpoint}), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    rule = 8'h01;
    do_step();
    check("post_rst_out", 32'(out), 32'hFF);
    check("post_rst_gen", 32'(gen_count), 32'd1);
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
